// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage pipeline register for the five-stage MIPS core. One instance
// sits on any stage boundary (F/D, D/E, E/M, M/W) and carries instruction,
// PC, PC+4, valid, exception code and the branch-delay flag. It also keeps
// saturating stall/flush performance counters and a sticky hang detector
// that fires when the stage has been held for STALL_LIMIT consecutive cycles.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   stall       hold all stage contents this cycle
//   flush       load a bubble (NOP) this cycle; wins over stall
//   cnt_clr     synchronous clear of counters, run counter and hang_err
//   ir_in       incoming instruction
//   pc_in       incoming PC
//   valid_in    incoming slot holds a real instruction
//   excode_in   incoming exception code (0 = none)
//   bd_in       incoming instruction sits in a branch delay slot
//   ir_out      registered instruction
//   pc_out      registered PC
//   pc4_out     registered PC+4
//   valid_out   registered valid
//   excode_out  registered exception code
//   bd_out      registered delay-slot flag
//   stall_cnt   cycles in which the hold took effect (saturating)
//   flush_cnt   cycles in which flush was asserted (saturating)
//   hang_err    sticky: stall lasted STALL_LIMIT consecutive cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W           = 32,
    parameter logic [DATA_W-1:0]  PC_RESET         = DATA_W'(32'h0000_3000),
    parameter int                 EXC_W            = 5,
    parameter int                 CNT_W            = 16,
    parameter bit                 KEEP_PC_ON_FLUSH = 1'b1,
    parameter int                 STALL_LIMIT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic [DATA_W-1:0] ir_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              valid_in,
    input  logic [EXC_W-1:0]  excode_in,
    input  logic              bd_in,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic              valid_out,
    output logic [EXC_W-1:0]  excode_out,
    output logic              bd_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              hang_err
);

    localparam logic [DATA_W-1:0] PC4_RESET = PC_RESET + DATA_W'(4);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STALL_LIMIT);

    // Pipeline data registers
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_pc4;
    logic              r_valid;
    logic [EXC_W-1:0]  r_excode;
    logic              r_bd;

    // Performance / hang-detection registers
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0]  r_run_cnt;
    logic              r_hang;

    logic              w_hold;
    logic [DATA_W-1:0] w_pc4_in;
    logic [CNT_W-1:0]  w_stall_cnt_next;
    logic [CNT_W-1:0]  w_flush_cnt_next;
    logic [CNT_W-1:0]  w_run_cnt_next;
    logic              w_hang_next;

    // A stall only takes effect when no flush is pending in the same cycle.
    assign w_hold   = stall & ~flush;
    // Carry out of the PC+4 add is deliberately dropped (address wraps).
    assign w_pc4_in = pc_in + DATA_W'(4);

    // ------------------------------------------------------------------
    // Data path: flush > stall > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir     <= '0;
            r_pc     <= PC_RESET;
            r_pc4    <= PC4_RESET;
            r_valid  <= 1'b0;
            r_excode <= '0;
            r_bd     <= 1'b0;
        end else if (flush) begin
            r_ir     <= '0;
            r_valid  <= 1'b0;
            r_excode <= '0;
            // Keeping the PC on a bubble lets exception/EPC logic downstream
            // still see where the squashed slot came from.
            if (KEEP_PC_ON_FLUSH) begin
                r_pc  <= pc_in;
                r_pc4 <= w_pc4_in;
                r_bd  <= bd_in;
            end else begin
                r_pc  <= PC_RESET;
                r_pc4 <= PC4_RESET;
                r_bd  <= 1'b0;
            end
        end else if (!stall) begin
            // valid_in=0 still captures every field; consumers qualify on valid.
            r_ir     <= ir_in;
            r_pc     <= pc_in;
            r_pc4    <= w_pc4_in;
            r_valid  <= valid_in;
            r_excode <= excode_in;
            r_bd     <= bd_in;
        end
    end

    // ------------------------------------------------------------------
    // Counter next-state: saturating increments, run counter tracks the
    // current unbroken stretch of effective stalls.
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_cnt_next = r_stall_cnt;
        w_flush_cnt_next = r_flush_cnt;
        w_run_cnt_next   = '0;
        w_hang_next      = r_hang;

        if (w_hold) begin
            if (r_stall_cnt != CNT_MAX) begin
                w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
            end
            if (r_run_cnt != CNT_MAX) begin
                w_run_cnt_next = r_run_cnt + CNT_W'(1);
            end else begin
                w_run_cnt_next = r_run_cnt;
            end
            if (w_run_cnt_next == LIMIT) begin
                w_hang_next = 1'b1;
            end
        end

        if (flush && (r_flush_cnt != CNT_MAX)) begin
            w_flush_cnt_next = r_flush_cnt + CNT_W'(1);
        end

        // Clear overrides any increment or hang set in the same cycle.
        if (cnt_clr) begin
            w_stall_cnt_next = '0;
            w_flush_cnt_next = '0;
            w_run_cnt_next   = '0;
            w_hang_next      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_run_cnt   <= '0;
            r_hang      <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_run_cnt   <= w_run_cnt_next;
            r_hang      <= w_hang_next;
        end
    end

    assign ir_out     = r_ir;
    assign pc_out     = r_pc;
    assign pc4_out    = r_pc4;
    assign valid_out  = r_valid;
    assign excode_out = r_excode;
    assign bd_out     = r_bd;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign hang_err   = r_hang;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core.
- One instance serves any boundary: F/D, D/E, E/M or M/W.
- Carries instruction, PC, PC+4, valid, exception code and branch-delay flag.
- Supports stall (hold), flush (NOP insertion), saturating stall/flush performance counters and a sticky hang detector for excessively long stalls.

Parameters:
- DATA_W, 32, width of instruction and PC fields.
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- EXC_W, 5, width of exception-code field.
- CNT_W, 16, width of each performance counter.
- KEEP_PC_ON_FLUSH, 1, 1 = PC/PC+4/bd_out keep the incoming values on flush; 0 = they load their reset values.
- STALL_LIMIT, 64, consecutive stall cycles that set hang_err; range 1..2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage contents this cycle.
- flush  in  1  load a bubble (NOP) this cycle.
- cnt_clr  in  1  synchronous clear of counters, run counter and hang_err.
- ir_in  in  DATA_W  incoming instruction.
- pc_in  in  DATA_W  incoming PC.
- valid_in  in  1  incoming slot holds a real instruction.
- excode_in  in  EXC_W  incoming exception code (0 = none).
- bd_in  in  1  incoming instruction is in a branch delay slot.
- ir_out  out  DATA_W  registered instruction.
- pc_out  out  DATA_W  registered PC.
- pc4_out  out  DATA_W  registered PC+4.
- valid_out  out  1  registered valid.
- excode_out  out  EXC_W  registered exception code.
- bd_out  out  1  registered delay-slot flag.
- stall_cnt  out  CNT_W  cycles in which the hold took effect.
- flush_cnt  out  CNT_W  cycles in which flush was asserted.
- hang_err  out  1  sticky: stall lasted STALL_LIMIT consecutive cycles.

Behaviour:
- Reset (asynchronous, immediate, any cycle including mid-stall):
  - ir_out=0, pc_out=PC_RESET, pc4_out=PC_RESET+4, valid_out=0, excode_out=0, bd_out=0.
  - stall_cnt=0, flush_cnt=0, run counter=0, hang_err=0.
  - Deassertion takes effect at the next rising edge; no partial state survives.
- Per rising edge, priority is flush > stall > load:
  - Flush: ir_out=0, valid_out=0, excode_out=0.
    - KEEP_PC_ON_FLUSH=1: pc_out=pc_in, pc4_out=pc_in+4, bd_out=bd_in.
    - KEEP_PC_ON_FLUSH=0: pc_out=PC_RESET, pc4_out=PC_RESET+4, bd_out=0.
  - Stall (flush=0): all data outputs keep their values.
  - Load (flush=0, stall=0): each output takes its input; pc4_out=pc_in+4 (modulo 2^DATA_W, carry discarded).
- Latency is exactly one cycle from input to output when not stalled or flushed. The block is purely registered: no combinational path from input to output.
- Simultaneous stall and flush: flush wins. The cycle counts as flush only: flush_cnt increments, stall_cnt does not, and the run counter clears.
- stall_cnt: +1 on every edge with stall=1 and flush=0; saturates at all-ones.
- flush_cnt: +1 on every edge with flush=1; saturates at all-ones.
- Run counter (internal, CNT_W bits):
  - +1 on each edge with stall=1 and flush=0; saturates.
  - Clears to 0 on any edge with stall=0 or flush=1.
- hang_err: set on the edge where the run counter reaches STALL_LIMIT. Clears only via reset or cnt_clr.
- cnt_clr: on that edge, stall_cnt, flush_cnt, run counter and hang_err go to 0, overriding any increment or set in the same cycle. Pipeline data is unaffected by cnt_clr.
- With valid_in=0 on load, all fields are still captured as given; downstream consumers qualify on valid_out.

Test Plan:
- Reset: assert reset mid-cycle with the stage loaded.
  → Outputs change before the next edge: pc_out=0x3000, pc4_out=0x3004, ir_out=0, valid_out=0, counters 0.
- Load: ir_in=0x8C010004, pc_in=0x3010, valid_in=1.
  → After 1 edge: ir_out=0x8C010004, pc_out=0x3010, pc4_out=0x3014, valid_out=1.
- Stall: hold stall=1 for 3 edges while inputs change.
  → Outputs unchanged; stall_cnt=3. Release stall → next edge loads the new inputs.
- Flush with KEEP_PC_ON_FLUSH=1, stall=1 also high, pc_in=0x3020, bd_in=1.
  → ir_out=0, valid_out=0, pc_out=0x3020, pc4_out=0x3024, bd_out=1; flush_cnt=1, stall_cnt unchanged.
- Hang and wrap, with STALL_LIMIT=4, CNT_W=4:
  - Stall 4 consecutive edges → hang_err=1; deassert stall → hang_err stays 1; cnt_clr → hang_err=0, stall_cnt=0.
  - 20 further stall edges → stall_cnt saturates at 15.
  - pc_in=0xFFFFFFFC → pc4_out=0x00000000.
